// File: rtl/connect4_pkg.sv
// Board geometry, colour codes and FSM encoding shared by the cell draw engine.
// Constants only; no logic.
package connect4_pkg;
  localparam int CELL_W     = 4;
  localparam int CELL_PITCH = 6;
  localparam int COLS       = 7;
  localparam int ROWS       = 6;
  localparam int X_ORIGIN   = 20;
  localparam int Y_ORIGIN   = 20;
  localparam int POINTER_Y  = 10;
  localparam int LOG_W      = $clog2(CELL_W);

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic logic [2:0] player_colour(input logic player);
    return player ? COL_YELLOW : COL_RED;
  endfunction
endpackage

// File: rtl/cell_draw_engine_if.sv
// Request handshake from game logic plus the registered pixel/done stream to the VGA adapter.
interface cell_draw_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_kind;
  logic [2:0] req_col;
  logic [2:0] req_row;
  logic       req_player;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       err;

  modport master (
    output req_valid, req_kind, req_col, req_row, req_player,
    input  req_ready, x, y, colour, plot, done, err
  );

  modport slave (
    input  req_valid, req_kind, req_col, req_row, req_player,
    output req_ready, x, y, colour, plot, done, err
  );
endinterface

// File: rtl/cell_sweep.sv
// Raster pixel counter over a CELL_W x CELL_W square: one step per enabled cycle, x fastest.
// start clears the counter; it wraps to 0 after the last pixel so sweeps can run back-to-back.
module cell_sweep
  import connect4_pkg::*;
#(
  parameter int W_LOG = LOG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             en,
  output logic [W_LOG-1:0] dx,
  output logic [W_LOG-1:0] dy,
  output logic             last
);
  logic [2*W_LOG-1:0] pc;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc <= '0;
    end else if (start) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc + 1'b1;
    end
  end

  assign dx   = pc[W_LOG-1:0];
  assign dy   = pc[2*W_LOG-1:W_LOG];
  assign last = &pc;
endmodule

// File: rtl/cell_draw_engine.sv
// Draws a disc or the column pointer as a CELL_W square, one registered pixel per clock.
// One request in flight; req_ready is low from accept until the done pulse.
module cell_draw_engine
  import connect4_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  cell_draw_engine_if.slave   bus
);
  state_t     state, state_nx;
  logic       kind_q, player_q, err_q, ptr_valid;
  logic [2:0] col_q, row_q, ptr_col;
  logic       accept, req_bad, sweeping, last;
  logic [LOG_W-1:0] dx, dy;
  logic [2:0] sweep_col;
  logic [7:0] px;
  logic [6:0] py;
  logic [2:0] pcolour;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_bad       = (int'(bus.req_col) >= COLS) ||
                         (!bus.req_kind && (int'(bus.req_row) >= ROWS));
  assign sweeping      = (state == ST_ERASE) || (state == ST_DRAW);

  cell_sweep u_sweep (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .en     (sweeping),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)                          state_nx = ST_FINISH;
          else if (bus.req_kind && ptr_valid)   state_nx = ST_ERASE;
          else                                  state_nx = ST_DRAW;
        end
      end
      ST_ERASE:  if (last) state_nx = ST_DRAW;
      ST_DRAW:   if (last) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Erase always targets the old pointer row; everything else uses the latched request.
  always_comb begin
    sweep_col = (state == ST_ERASE) ? ptr_col : col_q;
    px        = 8'(X_ORIGIN + int'(sweep_col) * CELL_PITCH + int'(dx));
    if ((state == ST_ERASE) || kind_q)
      py = 7'(POINTER_Y + int'(dy));
    else
      py = 7'(Y_ORIGIN + (ROWS - 1 - int'(row_q)) * CELL_PITCH + int'(dy));
    pcolour = (state == ST_ERASE) ? COL_BLACK : player_colour(player_q);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= ST_IDLE;
      kind_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      player_q   <= 1'b0;
      err_q      <= 1'b0;
      ptr_col    <= '0;
      ptr_valid  <= 1'b0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        kind_q   <= bus.req_kind;
        col_q    <= bus.req_col;
        row_q    <= bus.req_row;
        player_q <= bus.req_player;
        err_q    <= req_bad;
      end
      if ((state == ST_DRAW) && last && kind_q) begin
        ptr_col   <= col_q;
        ptr_valid <= 1'b1;
      end
      bus.plot <= sweeping;
      if (sweeping) begin
        bus.x      <= px;
        bus.y      <= py;
        bus.colour <= pcolour;
      end
      bus.done <= (state == ST_FINISH);
      bus.err  <= (state == ST_FINISH) && err_q;
    end
  end
endmodule

// File: tb/tb_cell_draw_engine.sv
// Scoreboard bench: a driver pushes pixels/done predicted from board geometry, a negedge monitor pops and compares.
module tb_cell_draw_engine;
  import connect4_pkg::*;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic [31:0] cyc;
  } pix_t;

  typedef struct packed {
    logic        err;
    logic [31:0] cyc;
  } done_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  cell_draw_engine_if bus();
  cell_draw_engine dut (.clk(clk), .resetn(resetn), .bus(bus));

  pix_t  pix_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    mon_on = 1'b1;
  int    ptr_col_m = 0;
  bit    ptr_valid_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_square(input int bx, input int by, input logic [2:0] c, input int start);
    for (int r = 0; r < CELL_W; r++)
      for (int k = 0; k < CELL_W; k++)
        pix_q.push_back('{x: 8'(bx + k), y: 7'(by + r), colour: c, cyc: 32'(start + r * CELL_W + k)});
  endfunction

  // Called on the negedge just before the accepting posedge.
  function automatic void expect_req(input logic kind, input int col, input int row, input logic player);
    int  a;
    int  n;
    bit  berr;
    int  by;
    a    = cyc + 1;
    n    = 0;
    berr = (col >= 7) || (!kind && row >= 6);
    if (!berr) begin
      if (kind && ptr_valid_m) begin
        push_square(20 + ptr_col_m * 6, 10, 3'b000, a + 1);
        n = 16;
      end
      by = kind ? 10 : 20 + (5 - row) * 6;
      push_square(20 + col * 6, by, player ? 3'b110 : 3'b100, a + 1 + n);
      n += 16;
      if (kind) begin
        ptr_valid_m = 1'b1;
        ptr_col_m   = col;
      end
    end
    done_q.push_back('{err: berr, cyc: 32'(a + 1 + n)});
  endfunction

  always @(negedge clk) begin : monitor
    pix_t  pe;
    done_t de;
    if (mon_on && !resetn) begin
      if (bus.plot) begin
        if (pix_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_plot: x=%0d y=%0d colour=%b at cycle %0d", bus.x, bus.y, bus.colour, cyc);
        end else begin
          pe = pix_q.pop_front();
          check("pixel", {bus.x, bus.y, bus.colour, 32'(cyc)}, pe);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: err=%0b at cycle %0d", bus.err, cyc);
        end else begin
          de = done_q.pop_front();
          check("done_err_cycle", {bus.err, 32'(cyc)}, de);
        end
      end
    end
  end

  task automatic drive(input logic kind, input int col, input int row, input logic player);
    bus.req_valid  = 1'b1;
    bus.req_kind   = kind;
    bus.req_col    = 3'(col);
    bus.req_row    = 3'(row);
    bus.req_player = player;
  endtask

  task automatic wait_ready(output int t);
    t = 0;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", t);
    end
  endtask

  task automatic send(input logic kind, input int col, input int row, input logic player);
    int t;
    @(negedge clk);
    drive(kind, col, row, player);
    wait_ready(t);
    expect_req(kind, col, row, player);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((pix_q.size() != 0 || done_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (pix_q.size() != 0 || done_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d pixels and %0d done still pending", pix_q.size(), done_q.size());
      pix_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    int t;
    bus.req_valid  = 1'b0;
    bus.req_kind   = 1'b0;
    bus.req_col    = '0;
    bus.req_row    = '0;
    bus.req_player = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_plot",   bus.plot, 0);
    check("rst_done",   bus.done, 0);
    check("rst_err",    bus.err, 0);
    check("rst_xyc",    {bus.x, bus.y, bus.colour}, 0);
    check("rst_ready",  bus.req_ready, 1);
    resetn = 1'b0;

    send(0, 2, 0, 0); wait_idle();          // disc bottom row
    send(1, 3, 0, 1); wait_idle();          // first pointer, no erase
    send(1, 5, 0, 1); wait_idle();          // pointer move: erase then draw
    send(0, 7, 0, 0);                       // column out of range
    @(negedge clk);
    check("err_ready_back", bus.req_ready, 1);
    wait_idle();
    send(0, 3, 6, 1); wait_idle();          // row out of range
    send(1, 5, 7, 0); wait_idle();          // same column, row ignored
    send(0, 6, 5, 1); wait_idle();          // top-right cell

    // Inputs change during the sweep while valid stays high.
    @(negedge clk);
    drive(0, 1, 2, 1);
    wait_ready(t);
    expect_req(0, 1, 2, 1);
    @(negedge clk);
    drive(0, 4, 3, 0);
    wait_ready(t);
    check("held_busy_cycles", 64'(t), 17);
    expect_req(0, 4, 3, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
      wait_idle();
    end

    // Reset in the middle of a pointer move.
    send(1, 3, 0, 0); wait_idle();
    send(1, 6, 0, 1);
    repeat (6) @(negedge clk);
    #2;
    resetn = 1'b1;
    mon_on = 1'b0;
    pix_q.delete();
    done_q.delete();
    #1;
    check("midrst_plot",  bus.plot, 0);
    check("midrst_xyc",   {bus.x, bus.y, bus.colour}, 0);
    check("midrst_ready", bus.req_ready, 1);
    @(negedge clk);
    resetn      = 1'b0;
    ptr_valid_m = 1'b0;
    mon_on      = 1'b1;
    send(1, 2, 0, 1); wait_idle();          // must not erase after reset

    check("queues_empty", 64'(pix_q.size() + done_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
